// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit covering load-use bubbles, taken-branch flushes and data-memory waits.
// Control outputs are combinational from the FSM state; counters and the timeout flag are registered.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rsaddr_i,
  input  logic [4:0]       IFID_rtaddr_i,
  input  logic             IDEX_memread_i,
  input  logic [4:0]       IDEX_rtaddr_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [7:0]       wait_reg, wait_next;
  logic             err_reg, err_set;
  logic [CNT_W-1:0] stall_cnt_reg, bubble_cnt_reg;
  logic             lu, miss, hold_mem, id_eval;

  always_comb begin
    lu = IDEX_memread_i && (IDEX_rtaddr_i != 5'd0) &&
         ((IDEX_rtaddr_i == IFID_rsaddr_i) || (IDEX_rtaddr_i == IFID_rtaddr_i));
    miss = dmem_req_i && !dmem_ack_i;
  end

  // hold_mem freezes the whole pipe; id_eval lets ID-stage hazards (load-use, branch) act.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    pipe_stall_o  = 1'b0;
    state_next    = state_reg;
    wait_next     = wait_reg;
    err_set       = 1'b0;
    hold_mem      = 1'b0;
    id_eval       = 1'b0;

    if (rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      state_next   = RUN;
      wait_next    = 8'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (miss) begin
            hold_mem   = 1'b1;
            state_next = MEM_WAIT;
            wait_next  = 8'd0;
          end else begin
            id_eval = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            id_eval    = 1'b1;
            state_next = RUN;
          end else begin
            hold_mem = 1'b1;
            if (wait_reg == WAIT_LAST) begin
              err_set    = 1'b1;
              state_next = RUN;
            end else begin
              wait_next = wait_reg + 8'd1;
            end
          end
        end
        default: state_next = RUN;
      endcase

      if (hold_mem) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        pipe_stall_o = 1'b1;
      end else if (id_eval) begin
        if (lu) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= RUN;
      wait_reg       <= 8'd0;
      err_reg        <= 1'b0;
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (err_set) begin
        err_reg <= 1'b1;
      end
      // Counters saturate at all-ones rather than wrapping.
      if (!pc_write_o && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if (idex_bubble_o && (bubble_cnt_reg != '1)) begin
        bubble_cnt_reg <= bubble_cnt_reg + CNT_ONE;
      end
    end
  end

  assign err_o        = err_reg;
  assign stall_cnt_o  = stall_cnt_reg;
  assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and TIMEOUT=4/CNT_W=4) share stimulus and are
// checked against directed expectations and a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, ex_rt = '0;
  logic       memread = 1'b0, branch = 1'b0, req = 1'b0, ack = 1'b0;

  logic        d_pcw, d_ifw, d_bub, d_fl, d_st, d_err;
  logic [15:0] d_scnt, d_bcnt;
  logic        s_pcw, s_ifw, s_bub, s_fl, s_st, s_err;
  logic [3:0]  s_scnt, s_bcnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut_d (
    .clk_i(clk), .rst_i(rst), .IFID_rsaddr_i(rs), .IFID_rtaddr_i(rt),
    .IDEX_memread_i(memread), .IDEX_rtaddr_i(ex_rt), .branch_taken_i(branch),
    .dmem_req_i(req), .dmem_ack_i(ack),
    .pc_write_o(d_pcw), .ifid_write_o(d_ifw), .idex_bubble_o(d_bub), .ifid_flush_o(d_fl),
    .pipe_stall_o(d_st), .err_o(d_err), .stall_cnt_o(d_scnt), .bubble_cnt_o(d_bcnt)
  );

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .IFID_rsaddr_i(rs), .IFID_rtaddr_i(rt),
    .IDEX_memread_i(memread), .IDEX_rtaddr_i(ex_rt), .branch_taken_i(branch),
    .dmem_req_i(req), .dmem_ack_i(ack),
    .pc_write_o(s_pcw), .ifid_write_o(s_ifw), .idex_bubble_o(s_bub), .ifid_flush_o(s_fl),
    .pipe_stall_o(s_st), .err_o(s_err), .stall_cnt_o(s_scnt), .bubble_cnt_o(s_bcnt)
  );

  // Reference model: index 0 = default instance, 1 = small instance.
  bit m_wait[2];
  int m_waited[2];
  bit m_err[2];
  int m_stall[2];
  int m_bub[2];

  function automatic int tout(int k);
    return (k == 0) ? 64 : 4;
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // Expected {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_stall}.
  function automatic logic [4:0] model_ctl(int k);
    bit haz = memread && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
    bit frozen = m_wait[k] ? !ack : (req && !ack);
    if (rst) return 5'b00000;
    if (frozen) return 5'b00001;
    if (haz) return 5'b00100;
    if (branch) return 5'b11010;
    return 5'b11000;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_wait[k]   <= 1'b0;
        m_waited[k] <= 0;
        m_err[k]    <= 1'b0;
        m_stall[k]  <= 0;
        m_bub[k]    <= 0;
      end else begin
        if (((model_ctl(k) & 5'b10000) == 5'b0) && (m_stall[k] < cmax(k))) m_stall[k] <= m_stall[k] + 1;
        if (((model_ctl(k) & 5'b00100) != 5'b0) && (m_bub[k] < cmax(k))) m_bub[k] <= m_bub[k] + 1;
        if (!m_wait[k]) begin
          if (req && !ack) begin
            m_wait[k]   <= 1'b1;
            m_waited[k] <= 0;
          end
        end else if (ack) begin
          m_wait[k] <= 1'b0;
        end else if (m_waited[k] == tout(k) - 1) begin
          m_err[k]  <= 1'b1;
          m_wait[k] <= 1'b0;
        end else begin
          m_waited[k] <= m_waited[k] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = '0; rt = '0; ex_rt = '0;
    memread = 1'b0; branch = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st, s_pcw, s_ifw, s_bub, s_fl, s_st} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctl: got d=%b s=%b want 00000", {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st});
    end
    tick();
    @(negedge clk);
    checks++;
    if (d_scnt !== 16'd0 || d_bcnt !== 16'd0 || d_err !== 1'b0 || s_scnt !== 4'd0 || s_bcnt !== 4'd0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got d=%0d/%0d/%b s=%0d/%0d/%b want 0/0/0", d_scnt, d_bcnt, d_err, s_scnt, s_bcnt, s_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11000 || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_release: got d=%b s=%b want 11000", {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st});
    end
    $display("test_reset: done");
  endtask

  task automatic test_load_use();
    do_reset();
    memread = 1'b1; ex_rt = 5'd5; rt = 5'd5;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00100 || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b00100) begin
      errors++;
      $display("FAIL load_use_ctl: got d=%b s=%b want 00100", {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (d_bcnt !== 16'd1 || d_scnt !== 16'd1 || s_bcnt !== 4'd1 || s_scnt !== 4'd1) begin
      errors++;
      $display("FAIL load_use_cnt: got bubble=%0d stall=%0d (s %0d/%0d) want 1/1", d_bcnt, d_scnt, s_bcnt, s_scnt);
    end
    memread = 1'b1; ex_rt = 5'd0; rt = 5'd0; rs = 5'd0;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11000) begin
      errors++;
      $display("FAIL load_use_r0: got %b want 11000", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (d_bcnt !== 16'd1) begin
      errors++;
      $display("FAIL load_use_r0_cnt: got bubble=%0d want 1", d_bcnt);
    end
    $display("test_load_use: done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00001 || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b00001) begin
        errors++;
        $display("FAIL mem_wait_stall[%0d]: got d=%b s=%b want 00001", i, {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st});
      end
      tick();
    end
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11000 || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b11000) begin
      errors++;
      $display("FAIL mem_wait_ack: got d=%b s=%b want 11000", {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (d_scnt !== 16'd3 || s_scnt !== 4'd3 || d_pcw !== 1'b1 || d_st !== 1'b0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_after: got stall_cnt=%0d/%0d pcw=%b st=%b err=%b want 3/3 1 0 0", d_scnt, s_scnt, d_pcw, d_st, s_err);
    end
    $display("test_mem_wait: done");
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b00001 || s_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stall[%0d]: got %b err=%b want 00001 err=0", i, {s_pcw, s_ifw, s_bub, s_fl, s_st}, s_err);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (s_err !== 1'b1 || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== 5'b11000 || s_scnt !== 4'd5 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_set: got err=%b ctl=%b stall_cnt=%0d d_err=%b want 1 11000 5 0", s_err, {s_pcw, s_ifw, s_bub, s_fl, s_st}, s_scnt, d_err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (s_err !== 1'b1 || s_pcw !== 1'b1) begin
        errors++;
        $display("FAIL timeout_sticky[%0d]: got err=%b pcw=%b want 1 1", i, s_err, s_pcw);
      end
    end
    $display("test_timeout: done");
  endtask

  task automatic test_priority();
    do_reset();
    req = 1'b1; ack = 1'b0; memread = 1'b1; ex_rt = 5'd3; rs = 5'd3; branch = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00001) begin
      errors++;
      $display("FAIL prio_all: got %b want 00001", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    do_reset();
    memread = 1'b1; ex_rt = 5'd3; rs = 5'd3; branch = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00100) begin
      errors++;
      $display("FAIL prio_lu_br: got %b want 00100", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    tick();
    memread = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11010) begin
      errors++;
      $display("FAIL prio_br: got %b want 11010", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    $display("test_priority: done");
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    memread = 1'b1; ex_rt = 5'd7; rt = 5'd7;
    for (int i = 0; i < 20; i++) begin
      exp_cnt = (i < 15) ? i : 15;
      @(negedge clk);
      checks++;
      if (s_bcnt !== 4'(exp_cnt) || d_bcnt !== 16'(i)) begin
        errors++;
        $display("FAIL sat_progress[%0d]: got s=%0d d=%0d want %0d %0d", i, s_bcnt, d_bcnt, exp_cnt, i);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (s_bcnt !== 4'd15 || s_scnt !== 4'd15 || d_bcnt !== 16'd20 || d_scnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_final: got s=%0d/%0d d=%0d/%0d want 15/15 20/20", s_bcnt, s_scnt, d_bcnt, d_scnt);
    end
    $display("test_saturation: done");
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req = 1'b1; ack = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00000) begin
      errors++;
      $display("FAIL midwait_rst_ctl: got %b want 00000", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11000 || d_scnt !== 16'd0 || d_bcnt !== 16'd0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL midwait_after: got ctl=%b cnt=%0d/%0d err=%b want 11000 0/0 0", {d_pcw, d_ifw, d_bub, d_fl, d_st}, d_scnt, d_bcnt, d_err);
    end
    req = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b00001) begin
      errors++;
      $display("FAIL midwait_reenter: got %b want 00001", {d_pcw, d_ifw, d_bub, d_fl, d_st});
    end
    ack = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== 5'b11000 || d_scnt !== 16'd1) begin
      errors++;
      $display("FAIL midwait_done: got ctl=%b stall_cnt=%0d want 11000 1", {d_pcw, d_ifw, d_bub, d_fl, d_st}, d_scnt);
    end
    $display("test_reset_mid_wait: done");
  endtask

  task automatic test_random(int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      rst     = ($urandom_range(99) == 0);
      rs      = 5'($urandom_range(3));
      rt      = 5'($urandom_range(3));
      ex_rt   = 5'($urandom_range(3));
      memread = ($urandom_range(1) == 1);
      branch  = ($urandom_range(2) == 0);
      req     = ($urandom_range(2) == 0);
      ack     = (i < n / 2) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      @(negedge clk);
      checks++;
      if ({d_pcw, d_ifw, d_bub, d_fl, d_st} !== model_ctl(0) || {s_pcw, s_ifw, s_bub, s_fl, s_st} !== model_ctl(1)) begin
        errors++; bad++;
        $display("FAIL rand_ctl[%0d]: got d=%b s=%b want d=%b s=%b", i, {d_pcw, d_ifw, d_bub, d_fl, d_st}, {s_pcw, s_ifw, s_bub, s_fl, s_st}, model_ctl(0), model_ctl(1));
      end
      checks++;
      if (d_scnt !== 16'(m_stall[0]) || d_bcnt !== 16'(m_bub[0]) || d_err !== m_err[0] ||
          s_scnt !== 4'(m_stall[1]) || s_bcnt !== 4'(m_bub[1]) || s_err !== m_err[1]) begin
        errors++; bad++;
        $display("FAIL rand_regs[%0d]: got d=%0d/%0d/%b s=%0d/%0d/%b want d=%0d/%0d/%b s=%0d/%0d/%b", i,
                 d_scnt, d_bcnt, d_err, s_scnt, s_bcnt, s_err,
                 m_stall[0], m_bub[0], m_err[0], m_stall[1], m_bub[1], m_err[1]);
      end
    end
    rst = 1'b0;
    $display("test_random: %0d cycles, %0d bad", n, bad);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_saturation();
    test_reset_mid_wait();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
